// File: rtl/fp_normalize_sm_pkg.sv
// Shared constants and helpers for the sign-magnitude normaliser.
// Defaults match the fp_custom_adder result format.
package fp_normalize_sm_pkg;

  localparam int FXP_WIDTH_DEF     = 12;
  localparam int EXP_WIDTH_DEF     = 5;
  localparam int EXP_OUT_WIDTH_DEF = 5;

  function automatic int umax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_normalize_sm_lzc_count.sv
// Leading-zero counter: combinational priority encoder.
// An all-zero input yields WIDTH.
module lzc_count #(
  parameter int WIDTH = 12,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Scan LSB to MSB so the highest set bit wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_sm.sv
// Registered normaliser for packed {sign, exp, fxp} values.
// Shift is min(lz, exp) so the exponent clamps at zero.
module fp_normalize_sm
  import fp_normalize_sm_pkg::*;
#(
  parameter int FXP_WIDTH     = FXP_WIDTH_DEF,
  parameter int EXP_WIDTH     = EXP_WIDTH_DEF,
  parameter int EXP_OUT_WIDTH = EXP_OUT_WIDTH_DEF,
  localparam int OUT_W = 1 + EXP_OUT_WIDTH + FXP_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 sign,
  input  logic [FXP_WIDTH-1:0] fxp_in,
  input  logic [EXP_WIDTH-1:0] exp_in,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     fp_out
);

  localparam int FXP_LSB  = 0;
  localparam int EXP_LSB  = FXP_WIDTH;
  localparam int SIGN_BIT = FXP_WIDTH + EXP_OUT_WIDTH;
  localparam int LZW      = $clog2(FXP_WIDTH + 1);
  localparam int CMPW     = umax(LZW, EXP_WIDTH);

  if (EXP_OUT_WIDTH < EXP_WIDTH) begin : g_bad_width
    $error("EXP_OUT_WIDTH must be >= EXP_WIDTH");
  end

  logic [LZW-1:0]           lz;
  logic [CMPW-1:0]          lz_x;
  logic [CMPW-1:0]          exp_x;
  logic [CMPW-1:0]          sh;
  logic [CMPW-1:0]          exp_diff;
  logic [FXP_WIDTH-1:0]     fxp_sh;
  logic [EXP_OUT_WIDTH-1:0] exp_out;
  logic [OUT_W-1:0]         fp_next;

  lzc_count #(
    .WIDTH (FXP_WIDTH)
  ) u_lzc (
    .value (fxp_in),
    .count (lz)
  );

  // Compare at a common width so neither operand is truncated.
  assign lz_x  = CMPW'(lz);
  assign exp_x = CMPW'(exp_in);
  assign sh    = (lz_x < exp_x) ? lz_x : exp_x;

  assign fxp_sh   = fxp_in << sh;
  assign exp_diff = exp_x - sh;
  assign exp_out  = EXP_OUT_WIDTH'(exp_diff);

  // A zero magnitude collapses to canonical +0.
  always_comb begin
    fp_next = '0;
    if (|fxp_in) begin
      fp_next[SIGN_BIT]                 = sign;
      fp_next[EXP_LSB +: EXP_OUT_WIDTH] = exp_out;
      fp_next[FXP_LSB +: FXP_WIDTH]     = fxp_sh;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      fp_out    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) fp_out <= fp_next;
    end
  end

endmodule

// File: tb/tb_fp_normalize_sm.sv
// Scoreboard bench for fp_normalize_sm, default and 8-bit exponent outputs.
module tb_fp_normalize_sm;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        sign;
  logic [11:0] fxp_in;
  logic [4:0]  exp_in;
  logic        out_valid;
  logic [17:0] fp_out;
  logic        out_valid8;
  logic [20:0] fp_out8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [17:0] p5;
    logic [20:0] p8;
  } exp_t;

  exp_t sb[$];
  logic [17:0] hold5;
  logic [20:0] hold8;

  always #5 clk = ~clk;

  fp_normalize_sm dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .sign      (sign),
    .fxp_in    (fxp_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .fp_out    (fp_out)
  );

  fp_normalize_sm #(
    .EXP_OUT_WIDTH (8)
  ) dut8 (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .sign      (sign),
    .fxp_in    (fxp_in),
    .exp_in    (exp_in),
    .out_valid (out_valid8),
    .fp_out    (fp_out8)
  );

  task automatic model(input logic s, input logic [11:0] f,
                       input logic [4:0] e, output exp_t x);
    int lz;
    int shv;
    bit found;
    logic [11:0] fo;
    logic [4:0]  eo;
    lz = 0;
    found = 0;
    for (int i = 11; i >= 0; i--) begin
      if (!found) begin
        if (f[i]) found = 1;
        else lz++;
      end
    end
    shv = (lz < int'(e)) ? lz : int'(e);
    fo = f << shv;
    eo = e - 5'(shv);
    if (f == 12'h000) begin
      x.p5 = '0;
      x.p8 = '0;
    end else begin
      x.p5 = {s, eo, fo};
      x.p8 = {s, 3'b000, eo, fo};
    end
  endtask

  task automatic step(input string name, input logic v, input logic s,
                      input logic [11:0] f, input logic [4:0] e);
    exp_t x;
    in_valid = v;
    sign     = s;
    fxp_in   = f;
    exp_in   = e;
    if (v) begin
      model(s, f, e, x);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    if (v) begin
      x = sb.pop_front();
      hold5 = x.p5;
      hold8 = x.p8;
    end
    checks++;
    if (out_valid !== v || fp_out !== hold5) begin
      errors++;
      $display("FAIL %s: got v=%b fp=%h want v=%b fp=%h",
               name, out_valid, fp_out, v, hold5);
    end
    checks++;
    if (out_valid8 !== v || fp_out8 !== hold8) begin
      errors++;
      $display("FAIL %s_w8: got v=%b fp=%h want v=%b fp=%h",
               name, out_valid8, fp_out8, v, hold8);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    sign     = 1'b0;
    fxp_in   = '0;
    exp_in   = '0;
    hold5    = '0;
    hold8    = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fp_out !== 18'h0) begin
      errors++;
      $display("FAIL reset: got v=%b fp=%h want v=0 fp=0",
               out_valid, fp_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_normalize();
    step("full_pos", 1'b1, 1'b0, 12'h001, 5'd20);
    checks++;
    if (fp_out !== 18'h09800) begin
      errors++;
      $display("FAIL full_pos_const: got %h want 09800", fp_out);
    end
    step("full_neg", 1'b1, 1'b1, 12'h001, 5'd20);
    checks++;
    if (fp_out !== 18'h29800) begin
      errors++;
      $display("FAIL full_neg_const: got %h want 29800", fp_out);
    end
  endtask

  task automatic test_exp_clamp();
    step("clamp", 1'b1, 1'b0, 12'h010, 5'd3);
    checks++;
    if (fp_out !== 18'h00080) begin
      errors++;
      $display("FAIL clamp_const: got %h want 00080", fp_out);
    end
  endtask

  task automatic test_passthrough();
    step("pass_max", 1'b1, 1'b0, 12'hA00, 5'd31);
    checks++;
    if (fp_out !== 18'h1FA00) begin
      errors++;
      $display("FAIL pass_max_const: got %h want 1fa00", fp_out);
    end
    step("exp_zero", 1'b1, 1'b0, 12'h001, 5'd0);
    checks++;
    if (fp_out !== 18'h00001) begin
      errors++;
      $display("FAIL exp_zero_const: got %h want 00001", fp_out);
    end
  endtask

  task automatic test_zero();
    step("zero", 1'b1, 1'b1, 12'h000, 5'd17);
    checks++;
    if (fp_out !== 18'h00000) begin
      errors++;
      $display("FAIL zero_const: got %h want 00000", fp_out);
    end
  endtask

  task automatic test_back_to_back();
    step("b2b_0", 1'b1, 1'b1, 12'h0F3, 5'd2);
    step("b2b_1", 1'b1, 1'b0, 12'h004, 5'd12);
    step("b2b_2", 1'b1, 1'b1, 12'h7FF, 5'd1);
    step("idle_0", 1'b0, 1'b0, 12'h123, 5'd9);
    step("idle_1", 1'b0, 1'b1, 12'h001, 5'd30);
  endtask

  task automatic test_async_reset();
    step("pre_rst", 1'b1, 1'b1, 12'h030, 5'd25);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fp_out !== 18'h0 ||
        out_valid8 !== 1'b0 || fp_out8 !== 21'h0) begin
      errors++;
      $display("FAIL async_rst: got v=%b fp=%h want v=0 fp=0",
               out_valid, fp_out);
    end
    sb.delete();
    hold5 = '0;
    hold8 = '0;
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b0, 1'b0, 12'h000, 5'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      step("rand", 1'($urandom_range(0, 7) != 0), 1'($urandom),
           12'($urandom >> (($urandom % 12))), 5'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_full_normalize();
    test_exp_clamp();
    test_passthrough();
    test_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
